// File: rtl/alarm_controller.sv
// Alarm controller: BCD alarm time, match/trigger, ring timeout and optional snooze.
// Optional feature macro: ALARM_SNOOZE_EN (builds the SNOOZE state and snooze countdown).
module alarm_controller #(
    parameter int unsigned RING_SECS   = 60,
    parameter int unsigned SNOOZE_MINS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sec_tick,
    input  logic [12:0] time_bcd,
    input  logic [2:0]  sec_tens,
    input  logic [3:0]  sec_units,
    input  logic        alarm_set,
    input  logic        inc_h,
    input  logic        inc_m,
    input  logic        up_down,
    input  logic        arm,
    input  logic        snooze,
    input  logic        stop,
    output logic [12:0] alarm_time,
    output logic        ringing,
    output logic        snoozing,
    output logic        buzzer
);

    localparam int unsigned RING_W   = 8;
    localparam int unsigned SNZ_W    = 12;
    localparam int unsigned SNZ_LOAD = SNOOZE_MINS * 60;
    localparam logic [12:0] ALARM_RST = 13'h0380;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RING   = 2'd1;
`ifdef ALARM_SNOOZE_EN
    localparam logic [1:0] S_SNOOZE = 2'd2;
`endif

    logic [1:0]        state, state_nxt;
    logic [RING_W-1:0] ring_cnt, ring_cnt_nxt, ring_inc;
    logic [12:0]       alarm_nxt;
    logic              match, match_q, trigger;
`ifdef ALARM_SNOOZE_EN
    logic [SNZ_W-1:0]  snz_cnt, snz_cnt_nxt;
`endif

    // BCD hour step, 00..23 wrapping both ways
    function automatic logic [5:0] step_hour(input logic [5:0] h, input logic up);
        logic [1:0] t;
        logic [3:0] u;
        t = h[5:4];
        u = h[3:0];
        if (up) begin
            if (t == 2'd2 && u == 4'd3) begin
                t = 2'd0;
                u = 4'd0;
            end else if (u == 4'd9) begin
                t = t + 2'd1;
                u = 4'd0;
            end else begin
                u = u + 4'd1;
            end
        end else begin
            if (t == 2'd0 && u == 4'd0) begin
                t = 2'd2;
                u = 4'd3;
            end else if (u == 4'd0) begin
                t = t - 2'd1;
                u = 4'd9;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    // BCD minute step, 00..59 wrapping both ways
    function automatic logic [6:0] step_min(input logic [6:0] m, input logic up);
        logic [2:0] t;
        logic [3:0] u;
        t = m[6:4];
        u = m[3:0];
        if (up) begin
            if (u == 4'd9) begin
                u = 4'd0;
                t = (t == 3'd5) ? 3'd0 : t + 3'd1;
            end else begin
                u = u + 4'd1;
            end
        end else begin
            if (u == 4'd0) begin
                u = 4'd9;
                t = (t == 3'd0) ? 3'd5 : t - 3'd1;
            end else begin
                u = u - 4'd1;
            end
        end
        return {t, u};
    endfunction

    always_comb begin
        alarm_nxt = alarm_time;
        if (alarm_set) begin
            if (inc_h) alarm_nxt[12:7] = step_hour(alarm_time[12:7], up_down);
            if (inc_m) alarm_nxt[6:0]  = step_min(alarm_time[6:0], up_down);
        end
    end

    // Rising edge of match fires once per alarm minute
    assign match   = arm & ~alarm_set & (time_bcd == alarm_time)
                   & (sec_tens == 3'd0) & (sec_units == 4'd0);
    assign trigger = match & ~match_q;
    assign ring_inc = (ring_cnt == {RING_W{1'b1}}) ? ring_cnt : ring_cnt + RING_W'(1);

    always_comb begin
        state_nxt    = state;
        ring_cnt_nxt = ring_cnt;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_nxt  = snz_cnt;
`endif
        if (!arm || alarm_set) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        state_nxt    = S_RING;
                        ring_cnt_nxt = '0;
                    end
                end
                S_RING: begin
                    if (stop) begin
                        state_nxt = S_IDLE;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_nxt   = S_SNOOZE;
                        snz_cnt_nxt = SNZ_W'(SNZ_LOAD);
`endif
                    end else if (sec_tick) begin
                        ring_cnt_nxt = ring_inc;
                        if (ring_inc >= RING_W'(RING_SECS)) state_nxt = S_IDLE;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                S_SNOOZE: begin
                    if (stop) begin
                        state_nxt = S_IDLE;
                    end else if (sec_tick) begin
                        snz_cnt_nxt = (snz_cnt == '0) ? snz_cnt : snz_cnt - SNZ_W'(1);
                        if (snz_cnt == SNZ_W'(1)) begin
                            state_nxt    = S_RING;
                            ring_cnt_nxt = '0;
                        end
                    end
                end
`endif
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            ring_cnt   <= '0;
            match_q    <= 1'b0;
            alarm_time <= ALARM_RST;
            ringing    <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt    <= '0;
            snoozing   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            ring_cnt   <= ring_cnt_nxt;
            match_q    <= match;
            alarm_time <= alarm_nxt;
            ringing    <= (state_nxt == S_RING);
`ifdef ALARM_SNOOZE_EN
            snz_cnt    <= snz_cnt_nxt;
            snoozing   <= (state_nxt == S_SNOOZE);
`endif
        end
    end

`ifndef ALARM_SNOOZE_EN
    logic [SNZ_W:0] unused_snz;
    assign unused_snz = {snooze, SNZ_W'(SNZ_LOAD)};
    assign snoozing   = 1'b0;
`endif

    // 1 s on / 1 s off beep while ringing
    assign buzzer = ringing & ~sec_units[0];

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller; expectations queued at drive time, popped at sample time.
module tb_alarm_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        sec_tick;
    logic [12:0] time_bcd;
    logic [2:0]  sec_tens;
    logic [3:0]  sec_units;
    logic        alarm_set, inc_h, inc_m, up_down, arm, snooze, stop;
    logic [12:0] alarm_time;
    logic        ringing, snoozing, buzzer;

    int n_pass  = 0;
    int n_total = 0;
    string       tag_q[$];
    logic [12:0] exp_q[$];

    always #5 clk = ~clk;

    alarm_controller dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .time_bcd(time_bcd),
        .sec_tens(sec_tens), .sec_units(sec_units), .alarm_set(alarm_set),
        .inc_h(inc_h), .inc_m(inc_m), .up_down(up_down), .arm(arm),
        .snooze(snooze), .stop(stop), .alarm_time(alarm_time),
        .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
    );

    task automatic exp_push(input string tag, input logic [12:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk_pop(input logic [12:0] obs);
        string       t;
        logic [12:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_underflow: observed 0x%0h required <none>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed 0x%0h required 0x%0h", t, obs, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input logic [12:0] t, input logic [2:0] st, input logic [3:0] su);
        time_bcd  = t;
        sec_tens  = st;
        sec_units = su;
    endtask

    task automatic pulse_adj(input logic h, input logic m, input int n);
        repeat (n) begin
            inc_h = h;
            inc_m = m;
            step(1);
            inc_h = 1'b0;
            inc_m = 1'b0;
            step(1);
        end
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        step(1);
        sec_tick = 1'b0;
        step(1);
    endtask

    // Leave 07:00:00 for a cycle, then return to it so the match edge triggers
    task automatic fire(input string tag);
        set_time(13'h0380, 3'd0, 4'd1);
        step(1);
        set_time(13'h0380, 3'd0, 4'd0);
        exp_push(tag, 13'd1);
        step(1);
        chk_pop(13'(ringing));
    endtask

    task automatic check_sig(input string tag, input logic [12:0] obs, input logic [12:0] e);
        exp_push(tag, e);
        chk_pop(obs);
    endtask

    initial begin
        rst = 1'b0;
        sec_tick = 1'b0; alarm_set = 1'b0; inc_h = 1'b0; inc_m = 1'b0;
        up_down = 1'b0; arm = 1'b0; snooze = 1'b0; stop = 1'b0;
        set_time(13'h0000, 3'd0, 4'd0);
        step(2);
        check_sig("rst_alarm_time", alarm_time, 13'h0380);
        check_sig("rst_ringing", 13'(ringing), 13'd0);
        check_sig("rst_snoozing", 13'(snoozing), 13'd0);
        check_sig("rst_buzzer", 13'(buzzer), 13'd0);
        rst = 1'b1;
        step(1);

        // Adjust: hours down 8 from 07 -> 23, minutes up 61 from 00 -> 01
        alarm_set = 1'b1;
        up_down   = 1'b0;
        pulse_adj(1'b1, 1'b0, 8);
        check_sig("adj_hours_down", alarm_time, 13'h1180);
        up_down = 1'b1;
        pulse_adj(1'b0, 1'b1, 61);
        check_sig("adj_mins_up", alarm_time, 13'h1181);
        pulse_adj(1'b1, 1'b1, 1);
        check_sig("adj_both_up", alarm_time, 13'h0002);
        up_down = 1'b0;
        pulse_adj(1'b1, 1'b1, 1);
        check_sig("adj_both_down", alarm_time, 13'h1181);
        up_down = 1'b1;
        pulse_adj(1'b1, 1'b0, 8);
        up_down = 1'b0;
        pulse_adj(1'b0, 1'b1, 1);
        check_sig("adj_restore", alarm_time, 13'h0380);
        alarm_set = 1'b0;
        up_down   = 1'b1;
        pulse_adj(1'b1, 1'b1, 2);
        check_sig("adj_ignored", alarm_time, 13'h0380);

        // Fire once at 07:00:00
        arm = 1'b1;
        set_time(13'h0359, 3'd5, 4'd9);
        sec_tick = 1'b1;
        exp_push("pre_match_ringing", 13'd0);
        step(1);
        chk_pop(13'(ringing));
        set_time(13'h0380, 3'd0, 4'd0);
        exp_push("fire_ringing", 13'd1);
        step(1);
        chk_pop(13'(ringing));
        sec_tick = 1'b0;
        check_sig("fire_buzzer", 13'(buzzer), 13'd1);
        stop = 1'b1;
        exp_push("stop_ringing", 13'd0);
        step(1);
        chk_pop(13'(ringing));
        stop = 1'b0;
        exp_push("no_retrigger", 13'd0);
        step(20);
        chk_pop(13'(ringing));

        // Timeout after RING_SECS ticks, buzzer follows sec_units[0]
        fire("timeout_fire");
        for (int i = 1; i <= 60; i++) begin
            logic ring_e;
            logic [3:0] su;
            ring_e = (i < 60);
            su = 4'((i % 60) % 10);
            set_time((i == 60) ? 13'h0381 : 13'h0380, 3'((i % 60) / 10), su);
            sec_tick = 1'b1;
            exp_push($sformatf("timeout_ringing_%0d", i), 13'(ring_e));
            exp_push($sformatf("timeout_buzzer_%0d", i), 13'(ring_e & ~su[0]));
            step(1);
            chk_pop(13'(ringing));
            chk_pop(13'(buzzer));
            sec_tick = 1'b0;
            step(1);
        end

        // Snooze
        fire("snooze_fire");
        snooze = 1'b1;
`ifdef ALARM_SNOOZE_EN
        exp_push("snooze_ringing", 13'd0);
        exp_push("snooze_snoozing", 13'd1);
`else
        exp_push("snooze_ignored_ringing", 13'd1);
        exp_push("snooze_ignored_snoozing", 13'd0);
`endif
        step(1);
        snooze = 1'b0;
        chk_pop(13'(ringing));
        chk_pop(13'(snoozing));
        set_time(13'h0381, 3'd0, 4'd1);
`ifdef ALARM_SNOOZE_EN
        repeat (299) tick();
        check_sig("snooze_299_snoozing", 13'(snoozing), 13'd1);
        check_sig("snooze_299_ringing", 13'(ringing), 13'd0);
        sec_tick = 1'b1;
        exp_push("snooze_expire_ringing", 13'd1);
        exp_push("snooze_expire_snoozing", 13'd0);
        step(1);
        chk_pop(13'(ringing));
        chk_pop(13'(snoozing));
        sec_tick = 1'b0;
        step(1);
`endif
        stop = 1'b1;
        exp_push("snooze_stop_ringing", 13'd0);
        exp_push("snooze_stop_snoozing", 13'd0);
        step(1);
        stop = 1'b0;
        chk_pop(13'(ringing));
        chk_pop(13'(snoozing));

        // Priority: stop beats snooze and sec_tick
        fire("prio_fire");
        stop = 1'b1; snooze = 1'b1; sec_tick = 1'b1;
        exp_push("prio_ringing", 13'd0);
        exp_push("prio_snoozing", 13'd0);
        step(1);
        stop = 1'b0; snooze = 1'b0; sec_tick = 1'b0;
        chk_pop(13'(ringing));
        chk_pop(13'(snoozing));

        // Disarm forces IDLE
        fire("disarm_fire");
`ifdef ALARM_SNOOZE_EN
        snooze = 1'b1;
        exp_push("disarm_pre_snoozing", 13'd1);
        step(1);
        snooze = 1'b0;
        chk_pop(13'(snoozing));
`endif
        arm = 1'b0;
        set_time(13'h0381, 3'd0, 4'd1);
        exp_push("disarm_ringing", 13'd0);
        exp_push("disarm_snoozing", 13'd0);
        step(1);
        chk_pop(13'(ringing));
        chk_pop(13'(snoozing));
        arm = 1'b1;
        step(1);

        // alarm_set masks the match; release at :00 fires
        alarm_set = 1'b1;
        up_down   = 1'b1;
        pulse_adj(1'b0, 1'b1, 1);
        set_time(13'h0381, 3'd0, 4'd0);
        step(3);
        check_sig("masked_ringing", 13'(ringing), 13'd0);
        check_sig("masked_alarm_time", alarm_time, 13'h0381);
        alarm_set = 1'b0;
        exp_push("release_ringing", 13'd1);
        step(1);
        chk_pop(13'(ringing));

        // Asynchronous reset mid-ring
        #2;
        rst = 1'b0;
        #1;
        check_sig("async_rst_ringing", 13'(ringing), 13'd0);
        check_sig("async_rst_snoozing", 13'(snoozing), 13'd0);
        check_sig("async_rst_buzzer", 13'(buzzer), 13'd0);
        check_sig("async_rst_alarm_time", alarm_time, 13'h0380);
        step(1);
        rst = 1'b1;
        step(2);

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL scoreboard_leftover: observed %0d required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
